// File: rtl/draw_layer_mux_pkg.sv
// Types and constants for the screen selector and its fade engine.
package draw_layer_mux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    SWAP,
    FADE_IN
  } fade_state_t;

  // Brightness runs 0..16; 16 means "pass colour through untouched"
  localparam int FADE_LVL_MAX = 16;
  localparam int LVL_W        = 5;

  // Colour channel layout inside an RGB_B word
  localparam int CH_W = 4;
  localparam int N_CH = 3;

endpackage

// File: rtl/vga_pkg.sv
// Shared VGA timing types and colour width used by all screen renderers.
package vga_pkg;

  // 4/4/4 colour word
  localparam int RGB_B = 12;
  // Width of the horizontal / vertical pixel counters
  localparam int CNT_W = 11;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
  } vga_sig_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing bundle passed between the renderers and the output stage.
interface vga_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             hblnk;
  logic             vblnk;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);

endinterface

// File: rtl/draw_fade_scale.sv
// Combinational brightness scaler: each channel c becomes (c * lvl) >> 4.
module draw_fade_scale
  import vga_pkg::*;
  import draw_layer_mux_pkg::*;
(
  input  logic [RGB_B-1:0] rgb_i,
  input  logic [LVL_W-1:0] lvl_i,
  output logic [RGB_B-1:0] rgb_o
);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      // 4-bit channel times 5-bit level fits a 9-bit product
      logic [CH_W+LVL_W-1:0] prod;

      assign prod = {{LVL_W{1'b0}}, rgb_i[gi*CH_W +: CH_W]} * {{CH_W{1'b0}}, lvl_i};
      // lvl <= 16 keeps the shifted product within one channel
      assign rgb_o[gi*CH_W +: CH_W] = CH_W'(prod >> 4);
    end
  endgenerate

endmodule

// File: rtl/draw_layer_mux.sv
// Screen selector: picks one of N_SRC rendered screens, switching only at
// frame start, with an optional fade-to-black / fade-in between screens.
module draw_layer_mux
  import vga_pkg::*;
  import draw_layer_mux_pkg::*;
#(
  parameter int N_SRC           = 6,
  parameter int SEL_W           = $clog2(N_SRC),
  parameter int FRAMES_PER_STEP = 2,
  parameter int RST_SEL         = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  vga_if.in                      vga_in,
  input  logic [N_SRC*RGB_B-1:0] src_rgb,
  input  logic [SEL_W-1:0]       sel_i,
  vga_if.out                     vga_out,
  output logic [RGB_B-1:0]       rgb,
  output logic [SEL_W-1:0]       active_o,
  output logic                   busy_o,
  output logic                   sel_err_o
);

  localparam int FCNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int FPS_LAST = (FRAMES_PER_STEP > 0) ? FRAMES_PER_STEP - 1 : 0;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FADE_LVL_MAX);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(FADE_LVL_MAX - 1);

  fade_state_t        state_q, state_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic [SEL_W-1:0]   active_q, active_d;
  logic [SEL_W-1:0]   pending_q, pending_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [RGB_B-1:0]   rgb_q, rgb_d;
  vga_sig_t           vga_q, vga_d;
  logic               sel_err_q, sel_err_d;

  logic               fs;
  logic               step;
  logic               sel_ok;
  logic               req;
  logic [RGB_B-1:0]   src_arr [N_SRC];
  logic [RGB_B-1:0]   src_sel;
  logic [RGB_B-1:0]   src_scaled;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      assign src_arr[gi] = src_rgb[gi*RGB_B +: RGB_B];
    end
  endgenerate

  assign fs     = (vga_in.vcount == '0) && (vga_in.hcount == '0);
  assign step   = fs && (fcnt_q == FCNT_W'(FPS_LAST));
  assign sel_ok = ({1'b0, sel_i} < (SEL_W+1)'(N_SRC));
  assign req    = (pending_q != active_q);

  // Request capture: out-of-range selects are dropped and flagged
  always_comb begin
    pending_d = sel_ok ? sel_i : pending_q;
    sel_err_d = ~sel_ok;
  end

  // Next-state logic of the fade sequencer
  always_comb begin
    state_d = state_q;
    if (FRAMES_PER_STEP != 0) begin
      case (state_q)
        IDLE:     if (req) state_d = FADE_OUT;
        // A retarget from FADE_IN at level 0 is already black
        FADE_OUT: if (lvl_q == '0 || (step && lvl_q == LVL_ONE)) state_d = SWAP;
        SWAP:     if (fs) state_d = FADE_IN;
        FADE_IN: begin
          if (req)                            state_d = FADE_OUT;
          else if (step && lvl_q == LVL_LAST) state_d = IDLE;
        end
        default:  state_d = IDLE;
      endcase
    end
  end

  // Sequencer outputs: brightness, shown screen and frame counter
  always_comb begin
    lvl_d    = lvl_q;
    active_d = active_q;
    fcnt_d   = fcnt_q;
    if (fs) fcnt_d = step ? '0 : fcnt_q + FCNT_W'(1);
    if (FRAMES_PER_STEP == 0) begin
      fcnt_d = '0;
      if (fs && req) active_d = pending_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) fcnt_d = '0;
        end
        FADE_OUT: begin
          if (step && lvl_q != '0) lvl_d = lvl_q - LVL_ONE;
        end
        SWAP: begin
          if (fs) begin
            active_d = pending_q;
            fcnt_d   = '0;
          end
        end
        FADE_IN: begin
          if (req)       fcnt_d = '0;
          else if (step) lvl_d  = lvl_q + LVL_ONE;
        end
        default: ;
      endcase
    end
  end

  // Pixel path uses the post-update level/screen so the fs pixel already
  // belongs to the new frame's setting
  assign src_sel = src_arr[active_d];

  draw_fade_scale u_scale (
    .rgb_i (src_sel),
    .lvl_i (lvl_d),
    .rgb_o (src_scaled)
  );

  // Blank pixels are forced black; timing is passed through alongside
  always_comb begin
    rgb_d        = (vga_in.hblnk | vga_in.vblnk) ? '0 : src_scaled;
    vga_d.hcount = vga_in.hcount;
    vga_d.vcount = vga_in.vcount;
    vga_d.hsync  = vga_in.hsync;
    vga_d.vsync  = vga_in.vsync;
    vga_d.hblnk  = vga_in.hblnk;
    vga_d.vblnk  = vga_in.vblnk;
  end

  // State register and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lvl_q     <= LVL_FULL;
      active_q  <= SEL_W'(RST_SEL);
      pending_q <= SEL_W'(RST_SEL);
      fcnt_q    <= '0;
      rgb_q     <= '0;
      vga_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      fcnt_q    <= fcnt_d;
      rgb_q     <= rgb_d;
      vga_q     <= vga_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign rgb            = rgb_q;
  assign active_o       = active_q;
  assign busy_o         = (state_q != IDLE);
  assign sel_err_o      = sel_err_q;
  assign vga_out.hcount = vga_q.hcount;
  assign vga_out.vcount = vga_q.vcount;
  assign vga_out.hsync  = vga_q.hsync;
  assign vga_out.vsync  = vga_q.vsync;
  assign vga_out.hblnk  = vga_q.hblnk;
  assign vga_out.vblnk  = vga_q.vblnk;

endmodule

// File: tb/tb_draw_layer_mux.sv
// Bench for draw_layer_mux: a hard-switch instance (no fade) and a one-frame
// per step fading instance share a tiny 8x4 raster. Expected outputs are queued
// per cycle from a hand-written frame schedule and checked by a monitor.
module tb_draw_layer_mux;
  import vga_pkg::*;

  localparam int N     = 6;
  localparam int SW    = 3;
  localparam int H_TOT = 8;
  localparam int H_ACT = 6;
  localparam int V_ACT = 3;
  localparam int FRAME = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1;
  logic [N*RGB_B-1:0]   src_rgb = '0;
  logic [SW-1:0]        sel0 = '0, sel1 = '0;
  logic [RGB_B-1:0]     rgb0, rgb1;
  logic [SW-1:0]        act0, act1;
  logic                 busy0, busy1, err0, err1;

  vga_if vin();
  vga_if vout0();
  vga_if vout1();

  draw_layer_mux #(.N_SRC(N), .FRAMES_PER_STEP(0), .RST_SEL(0)) dut0 (
    .clk(clk), .rst(rst), .vga_in(vin), .src_rgb(src_rgb), .sel_i(sel0),
    .vga_out(vout0), .rgb(rgb0), .active_o(act0), .busy_o(busy0), .sel_err_o(err0)
  );

  draw_layer_mux #(.N_SRC(N), .FRAMES_PER_STEP(1), .RST_SEL(0)) dut1 (
    .clk(clk), .rst(rst), .vga_in(vin), .src_rgb(src_rgb), .sel_i(sel1),
    .vga_out(vout1), .rgb(rgb1), .active_o(act1), .busy_o(busy1), .sel_err_o(err1)
  );

  typedef struct {
    int unsigned  cyc;
    int           dut;
    logic [11:0]  rgb;
    logic [10:0]  hcnt;
    logic [2:0]   act;
    logic         busy;
    logic         err;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Next-cycle stimulus and the per-DUT frame expectation
  logic [RGB_B-1:0] sv [N];
  logic             nrst = 1'b1;
  logic [SW-1:0]    nsel0 = '0, nsel1 = '0;
  int               pos = 0;
  int               e_lvl [2];
  int               e_src [2];
  int               e_act [2];
  logic             e_busy [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] scale_exp(input logic [11:0] c, input int l);
    logic [11:0] r;
    for (int ch = 0; ch < 3; ch++) r[ch*4 +: 4] = 4'((int'(c[ch*4 +: 4]) * l) / 16);
    return r;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, d, cyc, got, expv);
    end
  endtask

  // One pixel clock: drive timing/selects, queue the response due next edge
  task automatic cycle();
    exp_t e;
    logic blank;
    @(posedge clk); #1;
    rst        = nrst;
    sel0       = nsel0;
    sel1       = nsel1;
    vin.hcount = 11'(pos % H_TOT);
    vin.vcount = 11'(pos / H_TOT);
    vin.hblnk  = (pos % H_TOT) >= H_ACT;
    vin.vblnk  = (pos / H_TOT) >= V_ACT;
    vin.hsync  = (pos % H_TOT) == H_TOT - 1;
    vin.vsync  = (pos / H_TOT) == V_ACT;
    for (int i = 0; i < N; i++) src_rgb[i*RGB_B +: RGB_B] = sv[i];
    blank = vin.hblnk | vin.vblnk;
    for (int d = 0; d < 2; d++) begin
      e.cyc = cyc + 1;
      e.dut = d;
      if (nrst) begin
        e.rgb = '0; e.hcnt = '0; e.act = '0; e.busy = 1'b0; e.err = 1'b0;
      end else begin
        e.rgb  = blank ? 12'h000 : scale_exp(sv[e_src[d]], e_lvl[d]);
        e.hcnt = 11'(pos % H_TOT);
        e.act  = 3'(e_act[d]);
        e.busy = e_busy[d];
        e.err  = ((d == 0) ? nsel0 : nsel1) >= 3'd6;
      end
      sb.push_back(e);
    end
    pos = (pos + 1) % FRAME;
  endtask

  task automatic to_fs();
    while (pos != 0) cycle();
  endtask

  task automatic frame();
    repeat (FRAME) cycle();
  endtask

  // Monitor: compares every queued response once its cycle has arrived
  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        chk("rgb",    0, 32'(rgb0),         32'(e.rgb));
        chk("hcount", 0, 32'(vout0.hcount), 32'(e.hcnt));
        chk("active", 0, 32'(act0),         32'(e.act));
        chk("busy",   0, 32'(busy0),        32'(e.busy));
        chk("selerr", 0, 32'(err0),         32'(e.err));
      end else begin
        chk("rgb",    1, 32'(rgb1),         32'(e.rgb));
        chk("hcount", 1, 32'(vout1.hcount), 32'(e.hcnt));
        chk("active", 1, 32'(act1),         32'(e.act));
        chk("busy",   1, 32'(busy1),        32'(e.busy));
        chk("selerr", 1, 32'(err1),         32'(e.err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    sv[0] = 12'hABC; sv[1] = 12'h888; sv[2] = 12'h4A2;
    sv[3] = 12'h5D7; sv[4] = 12'h0F0; sv[5] = 12'h123;
    for (int d = 0; d < 2; d++) begin
      e_lvl[d] = 16; e_src[d] = 0; e_act[d] = 0; e_busy[d] = 1'b0;
    end
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0;
    vin.vsync = 1'b0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;

    // Reset state, then blanking / pass-through with src0 = ABC
    nrst = 1'b1;
    repeat (3) cycle();
    nrst = 1'b0;
    to_fs();
    frame();

    // Hard switch (no fade): 0 -> 3 mid-frame, takes effect at next (0,0)
    repeat (10) cycle();
    nsel0 = 3'd3;
    to_fs();
    e_src[0] = 3; e_act[0] = 3;
    frame();

    // Out-of-range select: one error pulse, no fade started
    repeat (5) cycle();
    nsel1 = 3'd7;
    cycle();
    nsel1 = 3'd0;
    to_fs();
    frame();

    // Full fade FFF -> 888
    sv[0] = 12'hFFF;
    frame();
    repeat (10) cycle();
    nsel1 = 3'd1;
    cycle();
    e_busy[1] = 1'b1;
    to_fs();
    for (int k = 1; k <= 16; k++) begin
      e_lvl[1] = 16 - k;
      frame();
    end
    e_act[1] = 1; e_src[1] = 1; e_lvl[1] = 0;
    frame();
    for (int k = 1; k <= 16; k++) begin
      e_lvl[1] = k;
      if (k == 16) e_busy[1] = 1'b0;
      frame();
    end

    // Retarget during fade-out at lvl 8: target 0 becomes 2, 0 never shown
    frame();
    repeat (7) cycle();
    nsel1 = 3'd0;
    cycle();
    e_busy[1] = 1'b1;
    to_fs();
    for (int k = 1; k <= 16; k++) begin
      e_lvl[1] = 16 - k;
      if (k == 8) begin
        repeat (10) cycle();
        nsel1 = 3'd2;
        repeat (FRAME - 10) cycle();
      end else begin
        frame();
      end
    end
    e_act[1] = 2; e_src[1] = 2; e_lvl[1] = 0;
    frame();
    for (int k = 1; k <= 16; k++) begin
      e_lvl[1] = k;
      if (k == 16) e_busy[1] = 1'b0;
      frame();
    end

    // Reset during fade-in at lvl 5
    repeat (4) cycle();
    nsel1 = 3'd4;
    cycle();
    e_busy[1] = 1'b1;
    to_fs();
    for (int k = 1; k <= 16; k++) begin
      e_lvl[1] = 16 - k;
      frame();
    end
    e_act[1] = 4; e_src[1] = 4; e_lvl[1] = 0;
    frame();
    for (int k = 1; k <= 4; k++) begin
      e_lvl[1] = k;
      frame();
    end
    e_lvl[1] = 5;
    repeat (12) cycle();
    nrst = 1'b1; nsel0 = 3'd0; nsel1 = 3'd0;
    for (int d = 0; d < 2; d++) begin
      e_lvl[d] = 16; e_src[d] = 0; e_act[d] = 0; e_busy[d] = 1'b0;
    end
    repeat (2) cycle();
    nrst = 1'b0;
    to_fs();
    frame();

    repeat (3) @(negedge clk);
    chk("drain", 1, 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
